axis_interp_upsampler: RTL and testbench



---
 rtl/axis_interp_upsampler.sv | 126 ++++++++++++
 tb/tb_axis_interp_upsampler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_interp_upsampler.sv
// axis_interp_upsampler: linear-interpolating upsampler, emits INTERP_N interpolated
// samples per input interval, one per next_dv tick.
`timescale 1ns/1ps
module axis_interp_upsampler #(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int INTERP_N          = 64,
  parameter int INTERP_L          = 6
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic                         next_dv,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  output logic                         S_AXIS_tready,
  output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  output logic                         underrun
);
  localparam int S = SAXIS_TDATA_WIDTH;
  localparam int M = MAXIS_TDATA_WIDTH;
  localparam int L = INTERP_L;
  localparam int A = S + L + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [L-1:0] LAST = L'(INTERP_N - 1);

  logic [1:0]   state_q, state_d;
  logic [S-1:0] pend_q, pend_d, x0_q, x0_d, x1_q, x1_d;
  logic         pv_q, pv_d, rdy_q, rdy_d, mv_q, mv_d, und_q, und_d;
  logic [S:0]   delta_q, delta_d;
  logic [A-1:0] acc_q, acc_d;
  logic [L-1:0] step_q, step_d;
  logic [M-1:0] md_q, md_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    delta_d = delta_q;
    acc_d   = acc_q;
    step_d  = step_q;
    md_d    = md_q;
    mv_d    = 1'b0;
    und_d   = und_q;
    // accept and consume are mutually exclusive: accept needs the slot empty
    if (S_AXIS_tvalid && rdy_q) begin
      pend_d = S_AXIS_tdata;
      pv_d   = 1'b1;
    end
    case (state_q)
      IDLE: if (pv_q) begin
        x0_d    = pend_q;
        pv_d    = 1'b0;
        state_d = PRIME;
      end
      PRIME: if (pv_q) begin
        x1_d    = pend_q;
        delta_d = {pend_q[S-1], pend_q} - {x0_q[S-1], x0_q};
        acc_d   = {x0_q[S-1], x0_q, {L{1'b0}}};
        step_d  = '0;
        pv_d    = 1'b0;
        state_d = RUN;
      end
      RUN: if (next_dv) begin
        md_d   = acc_q[S+L-1 -: M];
        mv_d   = 1'b1;
        acc_d  = acc_q + {{L{delta_q[S]}}, delta_q};
        step_d = step_q + 1'b1;
        if (step_q == LAST) begin
          x0_d   = x1_q;
          acc_d  = {x1_q[S-1], x1_q, {L{1'b0}}};
          step_d = '0;
          if (pv_q) begin
            x1_d    = pend_q;
            delta_d = {pend_q[S-1], pend_q} - {x1_q[S-1], x1_q};
            pv_d    = 1'b0;
          end else begin
            delta_d = '0;
            und_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = !pv_d;
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q <= IDLE;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
      delta_q <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      md_q    <= '0;
      mv_q    <= 1'b0;
      und_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      delta_q <= delta_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      md_q    <= md_d;
      mv_q    <= mv_d;
      und_q   <= und_d;
      rdy_q   <= rdy_d;
    end
  end

  assign S_AXIS_tready = rdy_q;
  assign M_AXIS_tdata  = md_q;
  assign M_AXIS_tvalid = mv_q;
  assign underrun      = und_q;
endmodule

// File: tb/tb_axis_interp_upsampler.sv
// tb_axis_interp_upsampler: scoreboard bench; a 32-bit and a 16-bit output instance
// share one input stream, expected samples are queued per tick and popped by a monitor.
`timescale 1ns/1ps
module tb_axis_interp_upsampler;
  logic        a_clk = 1'b0, a_resetn = 1'b0, next_dv = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, s_ready2, m_valid, m_valid2, und, und2;
  logic [31:0] m_data;
  logic [15:0] m_data2;
  int          n_chk = 0, n_fail = 0, ticks = 0, d_tick = 0;
  logic [31:0] q[$];
  logic [15:0] q2[$];

  axis_interp_upsampler #(.SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(32), .INTERP_N(64), .INTERP_L(6)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .next_dv(next_dv), .S_AXIS_tdata(s_data),
    .S_AXIS_tvalid(s_valid), .S_AXIS_tready(s_ready), .M_AXIS_tdata(m_data),
    .M_AXIS_tvalid(m_valid), .underrun(und));

  axis_interp_upsampler #(.SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(16), .INTERP_N(64), .INTERP_L(6)) dut16 (
    .a_clk(a_clk), .a_resetn(a_resetn), .next_dv(next_dv), .S_AXIS_tdata(s_data),
    .S_AXIS_tvalid(s_valid), .S_AXIS_tready(s_ready2), .M_AXIS_tdata(m_data2),
    .M_AXIS_tvalid(m_valid2), .underrun(und2));

  always #5 a_clk = ~a_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge a_clk) begin
    if (m_valid) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out32: got unexpected sample %h, expected none at %0t", m_data, $time);
      end else chk("out32", m_data, q.pop_front());
    end
    if (m_valid2) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out16: got unexpected sample %h, expected none at %0t", m_data2, $time);
      end else chk("out16", {16'h0, m_data2}, {16'h0, q2.pop_front()});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  task automatic tick(input logic [31:0] e, input bit ex = 1'b1);
    next_dv = 1'b1;
    if (ex) begin
      q.push_back(e);
      q2.push_back(e[31:16]);
    end
    @(posedge a_clk);
    #1 next_dv = 1'b0;
    ticks++;
  endtask

  task automatic send(input logic [31:0] x);
    bit ok = 1'b0;
    int n = 0;
    s_valid = 1'b1;
    s_data  = x;
    do begin
      @(negedge a_clk);
      ok = s_ready;
      @(posedge a_clk);
      n++;
    end while (!ok && n < 400);
    #1 s_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: sample %h not accepted, expected accept within 400 cycles", x);
    end else chk("tready_drop", {31'h0, s_ready}, 32'h0);
  endtask

  task automatic prime(input logic [31:0] a, input logic [31:0] b);
    send(a);
    tick(0, 1'b0);
    send(b);
    tick(0, 1'b0);
  endtask

  task automatic do_reset;
    a_resetn = 1'b0;
    wait_cyc(2);
    a_resetn = 1'b1;
    wait_cyc(1);
  endtask

  task automatic drain(input string nm);
    wait_cyc(3);
    chk({nm, "_q32_empty"}, q.size(), 0);
    chk({nm, "_q16_empty"}, q2.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(2);
    chk("rst_tready", {31'h0, s_ready}, 1);
    chk("rst_tvalid", {31'h0, m_valid}, 0);
    chk("rst_tdata", m_data, 0);
    chk("rst_tdata16", {16'h0, m_data2}, 0);
    chk("rst_underrun", {31'h0, und}, 0);
    a_resetn = 1'b1;
    wait_cyc(1);
    // ramp 0,64,128 then hold with underrun
    prime(0, 64);
    send(128);
    for (int k = 0; k < 127; k++) tick(k);
    chk("ramp_und_before", {31'h0, und}, 0);
    tick(127);
    chk("ramp_und_after", {31'h0, und}, 1);
    repeat (8) tick(128);
    drain("ramp");
    // negative slope
    do_reset;
    chk("neg_und_cleared", {31'h0, und}, 0);
    prime(100, -28);
    for (int k = 0; k < 64; k++) tick(100 - 2 * k);
    repeat (4) tick(-28);
    drain("neg");
    // floor rounding
    do_reset;
    prime(0, -1);
    tick(0);
    repeat (66) tick(-1);
    drain("floor");
    // backpressure: fourth sample stalls until the first wrap
    do_reset;
    send(0);
    send(64);
    send(128);
    fork
      begin
        send(192);
        d_tick = ticks;
      end
      begin
        for (int k = 0; k < 191; k++) tick(k);
        chk("bp_und_before", {31'h0, und}, 0);
        tick(191);
        chk("bp_und_after", {31'h0, und}, 1);
        repeat (4) tick(192);
      end
    join
    chk("bp_stall_lo", {31'h0, (d_tick - ticks + 196) >= 64}, 1);
    chk("bp_stall_hi", {31'h0, (d_tick - ticks + 196) <= 127}, 1);
    drain("bp");
    // underrun then late sample
    do_reset;
    prime(1000, 1064);
    for (int k = 0; k < 63; k++) tick(1000 + k);
    chk("ur_und_before", {31'h0, und}, 0);
    tick(1063);
    chk("ur_und_after", {31'h0, und}, 1);
    repeat (5) tick(1064);
    send(1128);
    repeat (59) tick(1064);
    for (int k = 0; k < 64; k++) tick(1064 + k);
    repeat (3) tick(1128);
    chk("ur_und_sticky", {31'h0, und}, 1);
    drain("ur");
    // reset mid-run with a pending sample and underrun set
    do_reset;
    prime(0, 64);
    for (int k = 0; k < 64; k++) tick(k);
    chk("mr_und_set", {31'h0, und}, 1);
    send(128);
    repeat (30) tick(64);
    @(negedge a_clk);
    #1 a_resetn = 1'b0;
    #1;
    chk("mr_tready", {31'h0, s_ready}, 1);
    chk("mr_tvalid", {31'h0, m_valid}, 0);
    chk("mr_tdata", m_data, 0);
    chk("mr_underrun", {31'h0, und}, 0);
    chk("mr_q_empty", q.size(), 0);
    wait_cyc(1);
    a_resetn = 1'b1;
    repeat (3) tick(0, 1'b0);
    send(500);
    tick(0, 1'b0);
    tick(0, 1'b0);
    send(564);
    tick(0, 1'b0);
    for (int k = 0; k < 64; k++) tick(500 + k);
    tick(564);
    drain("mr");
    // truncation to 16 bits
    do_reset;
    prime(32'h0001_0000, 32'h0002_0000);
    for (int k = 0; k < 64; k++) tick(32'h0001_0000 + k * 1024);
    repeat (2) tick(32'h0002_0000);
    drain("trunc");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
